// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a five-stage pipeline with an iterative mult/div unit.
// It decodes the FD/DX/XM/MW instruction registers, then flags load-use hazards,
// no-bypass data hazards, mult/div RAW/WAW hazards and mult/div structural hazards.
// It also tracks the single outstanding mult/div and its destination register.
module hazard_scoreboard #(
    parameter int BYPASS_EN  = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      fd_ir,
    input  logic [31:0]      dx_ir,
    input  logic [31:0]      xm_ir,
    input  logic [31:0]      mw_ir,
    input  logic             flush,
    input  logic             md_ready,
    output logic             stall,
    output logic             hold_dx,
    output logic             md_busy,
    output logic [4:0]       md_dest,
    output logic             md_wb,
    output logic [4:0]       md_wb_reg,
    output logic             md_timeout,
    output logic [1:0]       stall_cause,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int               AGE_W     = $clog2(MD_TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MD_TIMEOUT);

    // Up to two source registers. A slot is valid only for a nonzero register,
    // so r0 can never produce a hazard.
    typedef struct packed {
        logic       a_v;
        logic [4:0] a;
        logic       b_v;
        logic [4:0] b;
    } src_t;

    typedef struct packed {
        logic       v;
        logic [4:0] r;
    } dst_t;

    function automatic src_t decode_src(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        src_t s;
        s = '0;
        case (op)
            OP_RTYPE:        begin s.a_v = 1'b1; s.a = rs; s.b_v = 1'b1; s.b = rt; end
            OP_ADDI, OP_LW:  begin s.a_v = 1'b1; s.a = rs; end
            OP_SW:           begin s.a_v = 1'b1; s.a = rs; s.b_v = 1'b1; s.b = rd; end
            OP_BNE, OP_BLT:  begin s.a_v = 1'b1; s.a = rd; s.b_v = 1'b1; s.b = rs; end
            OP_JR:           begin s.a_v = 1'b1; s.a = rd; end
            default:         s = '0;
        endcase
        s.a_v = s.a_v && (s.a != 5'd0);
        s.b_v = s.b_v && (s.b != 5'd0);
        return s;
    endfunction

    function automatic dst_t decode_dst(input logic [4:0] op, input logic [4:0] rd);
        dst_t d;
        d = '0;
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW: d.r = rd;
            OP_JAL:                   d.r = 5'd31;
            OP_SETX:                  d.r = 5'd30;
            default:                  d.r = 5'd0;
        endcase
        d.v = (d.r != 5'd0);
        return d;
    endfunction

    function automatic logic is_md(input logic [4:0] op, input logic [4:0] aluop);
        return (op == OP_RTYPE) && ((aluop == ALU_MULT) || (aluop == ALU_DIV));
    endfunction

    function automatic logic src_hit(input src_t s, input logic [4:0] r);
        return (s.a_v && (s.a == r)) || (s.b_v && (s.b == r));
    endfunction

    function automatic logic dst_hit(input dst_t d, input logic [4:0] r);
        return d.v && (d.r == r);
    endfunction

    logic             md_busy_q, md_busy_d;
    logic [4:0]       md_dest_q, md_dest_d;
    logic [AGE_W-1:0] md_age_q, md_age_d;
    logic             md_timeout_q, md_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    src_t fd_src;
    dst_t fd_dst, dx_dst, xm_dst, mw_dst;
    logic dx_md, xm_md, mw_md;
    logic load_use, nb_data, md_raw, md_struct;
    logic md_issue, md_complete;
    logic [1:0] cause;

    // Instruction fields that carry no hazard information are folded together here.
    logic unused_ir;
    assign unused_ir = ^{fd_ir, dx_ir, xm_ir, mw_ir};

    // Hazard detection and prioritised stall cause; a flush squashes FD/DX so nothing stalls.
    always_comb begin
        fd_src    = decode_src(fd_ir[31:27], fd_ir[26:22], fd_ir[21:17], fd_ir[16:12]);
        fd_dst    = decode_dst(fd_ir[31:27], fd_ir[26:22]);
        dx_dst    = decode_dst(dx_ir[31:27], dx_ir[26:22]);
        xm_dst    = decode_dst(xm_ir[31:27], xm_ir[26:22]);
        mw_dst    = decode_dst(mw_ir[31:27], mw_ir[26:22]);
        dx_md     = is_md(dx_ir[31:27], dx_ir[6:2]);
        xm_md     = is_md(xm_ir[31:27], xm_ir[6:2]);
        mw_md     = is_md(mw_ir[31:27], mw_ir[6:2]);
        load_use  = (dx_ir[31:27] == OP_LW) && src_hit(fd_src, dx_ir[26:22]);
        nb_data   = 1'b0;
        if (BYPASS_EN == 0) begin
            nb_data = (!dx_md && dx_dst.v && src_hit(fd_src, dx_dst.r)) ||
                      (!xm_md && xm_dst.v && src_hit(fd_src, xm_dst.r)) ||
                      (!mw_md && mw_dst.v && src_hit(fd_src, mw_dst.r));
        end
        md_raw    = md_busy_q && (src_hit(fd_src, md_dest_q) || dst_hit(fd_dst, md_dest_q));
        md_struct = dx_md && md_busy_q && !md_ready;
        cause     = 2'b00;
        if (flush)                    cause = 2'b00;
        else if (md_struct)           cause = 2'b11;
        else if (md_raw)              cause = 2'b10;
        else if (load_use || nb_data) cause = 2'b01;
    end

    // Mult/div tracking: issue and completion, age counter, sticky timeout, stall counter.
    always_comb begin
        md_complete  = md_ready && md_busy_q;
        md_issue     = dx_md && !flush && (!md_busy_q || md_ready);
        md_busy_d    = md_busy_q;
        md_dest_d    = md_dest_q;
        md_age_d     = md_age_q;
        if (md_issue) begin
            md_busy_d = 1'b1;
            md_dest_d = dx_ir[26:22];
            md_age_d  = '0;
        end else if (md_complete) begin
            md_busy_d = 1'b0;
            md_age_d  = '0;
        end else if (md_busy_q && (md_age_q != AGE_LIMIT)) begin
            md_age_d  = md_age_q + AGE_W'(1);
        end
        md_timeout_d = md_timeout_q || (md_age_d == AGE_LIMIT);
        stall_cnt_d  = stall_cnt_q;
        if ((cause != 2'b00) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; an outstanding mult/div is abandoned on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_busy_q    <= 1'b0;
            md_dest_q    <= 5'd0;
            md_age_q     <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            md_busy_q    <= md_busy_d;
            md_dest_q    <= md_dest_d;
            md_age_q     <= md_age_d;
            md_timeout_q <= md_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall       = (cause != 2'b00);
    assign hold_dx     = (cause == 2'b11);
    assign stall_cause = cause;
    assign md_busy     = md_busy_q;
    assign md_dest     = md_dest_q;
    assign md_wb       = md_complete;
    assign md_wb_reg   = md_dest_q;
    assign md_timeout  = md_timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a bypassed instance (A) and a no-bypass instance
// with a 2-bit stall counter (B) share the same stimulus.
module tb_hazard_scoreboard;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_ir, dx_ir, xm_ir, mw_ir;
    logic        flush, md_ready;

    logic        stall_a, hold_a, busy_a, wb_a, to_a;
    logic [4:0]  dest_a, wbr_a;
    logic [1:0]  cause_a;
    logic [15:0] cnt_a;
    logic        stall_b, hold_b, busy_b, wb_b, to_b;
    logic [4:0]  dest_b, wbr_b;
    logic [1:0]  cause_b;
    logic [1:0]  cnt_b;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    int m_busy, m_dest, m_age, m_to, m_cnt_a, m_cnt_b;

    hazard_scoreboard #(.BYPASS_EN(1), .MD_TIMEOUT(TO), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir),
        .mw_ir(mw_ir), .flush(flush), .md_ready(md_ready), .stall(stall_a),
        .hold_dx(hold_a), .md_busy(busy_a), .md_dest(dest_a), .md_wb(wb_a),
        .md_wb_reg(wbr_a), .md_timeout(to_a), .stall_cause(cause_a), .stall_cnt(cnt_a));

    hazard_scoreboard #(.BYPASS_EN(0), .MD_TIMEOUT(TO), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir),
        .mw_ir(mw_ir), .flush(flush), .md_ready(md_ready), .stall(stall_b),
        .hold_dx(hold_b), .md_busy(busy_b), .md_dest(dest_b), .md_wb(wb_b),
        .md_wb_reg(wbr_b), .md_timeout(to_b), .stall_cause(cause_b), .stall_cnt(cnt_b));

    always #5 clock = ~clock;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    // ---------------- reference model (register sets as bitmasks) ----------------
    function automatic logic [31:0] src_mask(input logic [31:0] ir);
        logic [31:0] m;
        int op, rd, rs, rt;
        op = int'(ir[31:27]); rd = int'(ir[26:22]); rs = int'(ir[21:17]); rt = int'(ir[16:12]);
        m = 32'd0;
        if (op == 0)                 begin m[rs] = 1'b1; m[rt] = 1'b1; end
        else if (op == 5 || op == 8) m[rs] = 1'b1;
        else if (op == 7)            begin m[rs] = 1'b1; m[rd] = 1'b1; end
        else if (op == 2 || op == 6) begin m[rd] = 1'b1; m[rs] = 1'b1; end
        else if (op == 4)            m[rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic [31:0] dst_mask(input logic [31:0] ir);
        logic [31:0] m;
        int op;
        op = int'(ir[31:27]);
        m = 32'd0;
        if (op == 0 || op == 5 || op == 8) m[ir[26:22]] = 1'b1;
        else if (op == 3)                  m[31] = 1'b1;
        else if (op == 21)                 m[30] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic bit m_is_md(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
    endfunction

    function automatic logic [31:0] nonmd_dst(input logic [31:0] ir);
        return m_is_md(ir) ? 32'd0 : dst_mask(ir);
    endfunction

    function automatic int m_cause(input bit bypass);
        logic [31:0] busy_reg;
        bit lu, nb;
        busy_reg = 32'd0;
        if (m_busy != 0) busy_reg[m_dest] = 1'b1;
        busy_reg[0] = 1'b0;
        lu = (dx_ir[31:27] == 5'd8) && ((src_mask(fd_ir) & dst_mask(dx_ir)) != 32'd0);
        nb = !bypass && ((src_mask(fd_ir) &
             (nonmd_dst(dx_ir) | nonmd_dst(xm_ir) | nonmd_dst(mw_ir))) != 32'd0);
        if (flush) return 0;
        if (m_is_md(dx_ir) && m_busy != 0 && !md_ready) return 3;
        if (((src_mask(fd_ir) | dst_mask(fd_ir)) & busy_reg) != 32'd0) return 2;
        if (lu || nb) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_dest = 0; m_age = 0; m_to = 0; m_cnt_a = 0; m_cnt_b = 0;
    endtask

    // One rising edge; the model advances from the inputs present before the edge.
    task automatic tick();
        int ca, cb;
        bit issue, complete;
        ca = m_cause(1'b1);
        cb = m_cause(1'b0);
        complete = md_ready && (m_busy != 0);
        issue = m_is_md(dx_ir) && !flush && (m_busy == 0 || md_ready);
        @(posedge clock);
        if (issue) begin
            m_busy = 1; m_dest = int'(dx_ir[26:22]); m_age = 0;
        end else if (complete) begin
            m_busy = 0; m_age = 0;
        end else if (m_busy != 0 && m_age < TO) begin
            m_age++;
        end
        if (m_age >= TO) m_to = 1;
        if (ca != 0 && m_cnt_a < 65535) m_cnt_a++;
        if (cb != 0 && m_cnt_b < 3) m_cnt_b++;
        #1;
    endtask

    task automatic set_ir(input logic [31:0] fd, input logic [31:0] dx,
                          input logic [31:0] xm, input logic [31:0] mw);
        fd_ir = fd; dx_ir = dx; xm_ir = xm; mw_ir = mw;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        set_ir(0, 0, 0, 0);
        flush = 1'b0; md_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; md_ready = 1'b1;
        set_ir(0, rtype(5'd4, 5'd1, 5'd2, 5'd6), 0, 0);
        model_clear();
        #2;
        cmp_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        cmp_cnt++; if (dest_a !== 5'd0) begin err_cnt++; $display("FAIL rst_dest: got %0d want 0", dest_a); end
        cmp_cnt++; if (wb_a !== 1'b0) begin err_cnt++; $display("FAIL rst_md_wb: got %b want 0", wb_a); end
        cmp_cnt++; if (to_a !== 1'b0) begin err_cnt++; $display("FAIL rst_timeout: got %b want 0", to_a); end
        cmp_cnt++; if (cnt_a !== 16'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d want 0", cnt_a); end
        cmp_cnt++; if ({stall_a, hold_a, cause_a} !== 4'b0000) begin err_cnt++;
            $display("FAIL rst_stall: got %b%b%b want 0000", stall_a, hold_a, cause_a); end
        @(negedge clock);
        reset = 1'b0; md_ready = 1'b0;
        set_ir(0, 0, 0, 0);
        #1;
    endtask

    task automatic test_load_use();
        set_ir(rtype(5'd6, 5'd5, 5'd7, 5'd0), itype(5'd8, 5'd5, 5'd2), 0, 0);
        #1;
        cmp_cnt++; if ({stall_a, hold_a, cause_a} !== 4'b1001) begin err_cnt++;
            $display("FAIL lu_add: got stall=%b hold=%b cause=%b want 1/0/01", stall_a, hold_a, cause_a); end
        tick();
        fd_ir = itype(5'd7, 5'd5, 5'd2);
        #1;
        cmp_cnt++; if (stall_a !== 1'b1) begin err_cnt++; $display("FAIL lu_sw: got %b want 1", stall_a); end
        tick();
        fd_ir = itype(5'd5, 5'd5, 5'd0);
        #1;
        cmp_cnt++; if (stall_a !== 1'b0) begin err_cnt++; $display("FAIL lu_addi_a: got %b want 0", stall_a); end
        cmp_cnt++; if (stall_b !== 1'b0) begin err_cnt++; $display("FAIL lu_addi_b: got %b want 0", stall_b); end
        tick();
    endtask

    task automatic test_bypass();
        set_ir(rtype(5'd9, 5'd3, 5'd1, 5'd1), 0, itype(5'd5, 5'd3, 5'd0), 0);
        #1;
        cmp_cnt++; if ({stall_b, cause_b} !== 3'b101) begin err_cnt++;
            $display("FAIL nb_xm: got stall=%b cause=%b want 1/01", stall_b, cause_b); end
        cmp_cnt++; if (stall_a !== 1'b0) begin err_cnt++; $display("FAIL byp_xm: got %b want 0", stall_a); end
        tick();
        set_ir(rtype(5'd9, 5'd3, 5'd1, 5'd1), 0, 0, itype(5'd5, 5'd3, 5'd0));
        #1;
        cmp_cnt++; if (stall_b !== 1'b1) begin err_cnt++; $display("FAIL nb_mw: got %b want 1", stall_b); end
        tick();
        set_ir(rtype(5'd9, 5'd3, 5'd1, 5'd1), 0, rtype(5'd3, 5'd1, 5'd2, 5'd6), 0);
        #1;
        cmp_cnt++; if (stall_b !== 1'b0) begin err_cnt++; $display("FAIL nb_md_excl: got %b want 0", stall_b); end
        tick();
    endtask

    task automatic test_md_raw();
        set_ir(0, rtype(5'd4, 5'd1, 5'd2, 5'd6), 0, 0);
        #1;
        tick();
        cmp_cnt++; if ({busy_a, dest_a} !== {1'b1, 5'd4}) begin err_cnt++;
            $display("FAIL raw_issue: got busy=%b dest=%0d want 1/4", busy_a, dest_a); end
        set_ir(rtype(5'd1, 5'd4, 5'd2, 5'd0), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp_cnt++; if ({stall_a, cause_a} !== 3'b110) begin err_cnt++;
                $display("FAIL raw_wait%0d: got stall=%b cause=%b want 1/10", i, stall_a, cause_a); end
            tick();
        end
        md_ready = 1'b1;
        #1;
        cmp_cnt++; if ({wb_a, wbr_a} !== {1'b1, 5'd4}) begin err_cnt++;
            $display("FAIL raw_wb: got wb=%b reg=%0d want 1/4", wb_a, wbr_a); end
        tick();
        md_ready = 1'b0;
        #1;
        cmp_cnt++; if ({stall_a, busy_a} !== 2'b00) begin err_cnt++;
            $display("FAIL raw_done: got stall=%b busy=%b want 0/0", stall_a, busy_a); end
        tick();
    endtask

    task automatic test_md_struct();
        set_ir(0, rtype(5'd4, 5'd1, 5'd2, 5'd6), 0, 0);
        #1;
        tick();
        dx_ir = rtype(5'd8, 5'd1, 5'd2, 5'd7);
        #1;
        cmp_cnt++; if ({stall_a, hold_a, cause_a} !== 4'b1111) begin err_cnt++;
            $display("FAIL st_hold: got stall=%b hold=%b cause=%b want 1/1/11", stall_a, hold_a, cause_a); end
        tick();
        md_ready = 1'b1;
        #1;
        cmp_cnt++; if ({hold_a, wb_a} !== 2'b01) begin err_cnt++;
            $display("FAIL st_ready: got hold=%b wb=%b want 0/1", hold_a, wb_a); end
        tick();
        md_ready = 1'b0; dx_ir = 0;
        #1;
        cmp_cnt++; if ({busy_a, dest_a} !== {1'b1, 5'd8}) begin err_cnt++;
            $display("FAIL st_reissue: got busy=%b dest=%0d want 1/8", busy_a, dest_a); end
        md_ready = 1'b1;
        tick();
        md_ready = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        set_ir(rtype(5'd1, 5'd4, 5'd2, 5'd0), rtype(5'd4, 5'd1, 5'd2, 5'd6), 0, 0);
        #1;
        cmp_cnt++; if (stall_a !== 1'b0) begin err_cnt++; $display("FAIL fl_stall: got %b want 0", stall_a); end
        tick();
        cmp_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL fl_noissue: got %b want 0", busy_a); end
        flush = 1'b0; fd_ir = 0;
        tick();
        flush = 1'b1; dx_ir = rtype(5'd8, 5'd1, 5'd2, 5'd7); fd_ir = rtype(5'd1, 5'd4, 5'd2, 5'd0);
        #1;
        cmp_cnt++; if ({stall_a, hold_a, cause_a} !== 4'b0000) begin err_cnt++;
            $display("FAIL fl_force0: got stall=%b hold=%b cause=%b want 0/0/00", stall_a, hold_a, cause_a); end
        tick();
        flush = 1'b0; set_ir(0, 0, 0, 0);
        #1;
        cmp_cnt++; if ({busy_a, dest_a} !== {1'b1, 5'd4}) begin err_cnt++;
            $display("FAIL fl_keep: got busy=%b dest=%0d want 1/4", busy_a, dest_a); end
        md_ready = 1'b1;
        tick();
        md_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        set_ir(0, rtype(5'd4, 5'd1, 5'd2, 5'd6), 0, 0);
        tick();
        set_ir(rtype(5'd1, 5'd4, 5'd2, 5'd0), 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) tick();
        cmp_cnt++; if (to_a !== 1'b0) begin err_cnt++; $display("FAIL to_early: got %b want 0", to_a); end
        tick();
        cmp_cnt++; if ({to_a, busy_a} !== 2'b11) begin err_cnt++;
            $display("FAIL to_set: got timeout=%b busy=%b want 1/1", to_a, busy_a); end
        tick();
        cmp_cnt++; if (to_a !== 1'b1) begin err_cnt++; $display("FAIL to_sticky: got %b want 1", to_a); end
        #2;
        reset = 1'b1; md_ready = 1'b1;
        model_clear();
        #1;
        cmp_cnt++; if ({busy_a, to_a, wb_a, stall_a} !== 4'b0000) begin err_cnt++;
            $display("FAIL arst_flags: got busy=%b to=%b wb=%b stall=%b want 0000", busy_a, to_a, wb_a, stall_a); end
        cmp_cnt++; if ({dest_a, cnt_a} !== 21'd0) begin err_cnt++;
            $display("FAIL arst_regs: got dest=%0d cnt=%0d want 0/0", dest_a, cnt_a); end
        @(negedge clock);
        reset = 1'b0; md_ready = 1'b0; set_ir(0, 0, 0, 0);
        #1;
    endtask

    task automatic test_counter();
        do_reset();
        set_ir(rtype(5'd6, 5'd5, 5'd7, 5'd0), itype(5'd8, 5'd5, 5'd2), 0, 0);
        for (int i = 0; i < 5; i++) tick();
        cmp_cnt++; if (cnt_a !== 16'd5) begin err_cnt++; $display("FAIL cnt5: got %0d want 5", cnt_a); end
        tick();
        cmp_cnt++; if (cnt_b !== 2'd3) begin err_cnt++; $display("FAIL cnt_sat: got %0d want 3", cnt_b); end
        cmp_cnt++; if (cnt_a !== 16'd6) begin err_cnt++; $display("FAIL cnt6: got %0d want 6", cnt_a); end
        set_ir(0, 0, 0, 0);
        tick();
        cmp_cnt++; if (cnt_a !== 16'd6) begin err_cnt++; $display("FAIL cnt_idle: got %0d want 6", cnt_a); end
    endtask

    function automatic logic [4:0] rreg();
        int k;
        k = $urandom_range(0, 5);
        if (k == 4) return 5'd30;
        if (k == 5) return 5'd31;
        return 5'(k);
    endfunction

    function automatic logic [31:0] rand_ir();
        case ($urandom_range(0, 11))
            0:  return rtype(rreg(), rreg(), rreg(), 5'd0);
            1:  return rtype(rreg(), rreg(), rreg(), 5'd1);
            2:  return rtype(rreg(), rreg(), rreg(), 5'd6);
            3:  return rtype(rreg(), rreg(), rreg(), 5'd7);
            4:  return itype(5'd5, rreg(), rreg());
            5:  return itype(5'd8, rreg(), rreg());
            6:  return itype(5'd7, rreg(), rreg());
            7:  return itype(5'd2, rreg(), rreg());
            8:  return itype(5'd6, rreg(), rreg());
            9:  return itype(5'd4, rreg(), rreg());
            10: return itype(5'd3, rreg(), rreg());
            default: return itype(5'd21, rreg(), rreg());
        endcase
    endfunction

    task automatic test_random();
        int ca, cb;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            set_ir(rand_ir(), rand_ir(), rand_ir(), rand_ir());
            flush    = ($urandom_range(0, 7) == 0);
            md_ready = ($urandom_range(0, 3) == 0);
            #1;
            ca = m_cause(1'b1);
            cb = m_cause(1'b0);
            cmp_cnt++; if ({stall_a, hold_a, cause_a} !== {ca != 0, ca == 3, 2'(ca)}) begin err_cnt++;
                $display("FAIL rnd_a_haz n=%0d: got %b%b%b want cause %0d", n, stall_a, hold_a, cause_a, ca); end
            cmp_cnt++; if ({stall_b, hold_b, cause_b} !== {cb != 0, cb == 3, 2'(cb)}) begin err_cnt++;
                $display("FAIL rnd_b_haz n=%0d: got %b%b%b want cause %0d", n, stall_b, hold_b, cause_b, cb); end
            cmp_cnt++; if ({busy_a, dest_a, to_a} !== {m_busy != 0, 5'(m_dest), m_to != 0}) begin err_cnt++;
                $display("FAIL rnd_md n=%0d: got busy=%b dest=%0d to=%b want %0d/%0d/%0d",
                         n, busy_a, dest_a, to_a, m_busy, m_dest, m_to); end
            cmp_cnt++; if ({wb_a, wbr_a} !== {md_ready && m_busy != 0, 5'(m_dest)}) begin err_cnt++;
                $display("FAIL rnd_wb n=%0d: got wb=%b reg=%0d want reg %0d", n, wb_a, wbr_a, m_dest); end
            cmp_cnt++; if ({cnt_a, cnt_b} !== {16'(m_cnt_a), 2'(m_cnt_b)}) begin err_cnt++;
                $display("FAIL rnd_cnt n=%0d: got %0d/%0d want %0d/%0d", n, cnt_a, cnt_b, m_cnt_a, m_cnt_b); end
            tick();
        end
        flush = 1'b0; md_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_bypass();
        test_md_raw();
        test_md_struct();
        test_flush();
        test_timeout();
        test_counter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
